// File: rtl/bcd_scan_display.sv
// ---------------------------------------------------------------------------
// bcd_scan_display
//
// Time-multiplexes four BCD digits onto a common-segment 4-digit 7-segment
// display. Each digit is preceded by an all-off guard interval to suppress
// ghosting. All four inputs are captured together once per frame, so a frame
// never shows a mix of old and new digits. Optional leading-zero blanking is
// evaluated on that captured snapshot.
//
// Ports:
//   clk        : system clock
//   rst_n      : synchronous reset, active-high (despite the name)
//   ones       : BCD digit 0 (rightmost)
//   tens       : BCD digit 1
//   hundreds   : BCD digit 2
//   thousands  : BCD digit 3 (leftmost)
//   seg        : segment drive {g,f,e,d,c,b,a}, registered
//   an         : digit enables, an[i] drives digit i, registered
//   frame_done : one-cycle pulse in the cycle after a snapshot is taken
// ---------------------------------------------------------------------------
module bcd_scan_display #(
    parameter int DIV          = 100000,
    parameter int BLANK_CYC    = 8,
    parameter int COMMON_ANODE = 1,
    parameter int BLANK_LZ     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);

    // One counter serves both phases, so it is sized for the longer one.
    localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    localparam logic [6:0] SEG_OFF = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = (COMMON_ANODE != 0) ? 4'hF  : 4'h0;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t          r_state;
    logic [1:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_snap;
    logic            r_started;
    logic [6:0]      r_seg;
    logic [3:0]      r_an;
    logic            r_frameDone;

    state_t          w_stateNext;
    logic [1:0]      w_idxNext;
    logic [CW-1:0]   w_cntNext;
    logic            w_snapTake;
    logic [3:0]      w_digit;
    logic [6:0]      w_segRaw;
    logic [3:0]      w_lzBlank;
    logic [3:0]      w_anOneHot;
    logic [6:0]      w_segNext;
    logic [3:0]      w_anNext;

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frameDone;

    // Leading-zero mask from the snapshot. An invalid digit (10..15) is
    // nonzero, so it stops blanking of everything to its right.
    always_comb begin
        w_lzBlank = 4'b0000;
        if (BLANK_LZ != 0) begin
            w_lzBlank[3] = (r_snap[15:12] == 4'd0);
            w_lzBlank[2] = (r_snap[15:12] == 4'd0) && (r_snap[11:8] == 4'd0);
            w_lzBlank[1] = (r_snap[15:12] == 4'd0) && (r_snap[11:8] == 4'd0)
                           && (r_snap[7:4] == 4'd0);
        end
    end

    // Scan sequencer. The very first cycle out of reset only takes the
    // snapshot and holds BLANK/cnt=0, which makes it line up exactly with the
    // cycle that follows the end-of-frame snapshot in steady state.
    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        w_cntNext   = r_cnt;
        w_snapTake  = 1'b0;
        if (!r_started) begin
            w_snapTake = 1'b1;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_cntNext   = '0;
                        w_stateNext = ST_SHOW;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == DIV_LAST) begin
                        w_cntNext   = '0;
                        w_idxNext   = r_idx + 2'd1;
                        w_stateNext = ST_BLANK;
                        if (r_idx == 2'd3) begin
                            w_snapTake = 1'b1;
                        end
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_cntNext   = '0;
                    w_idxNext   = 2'd0;
                    w_stateNext = ST_BLANK;
                end
            endcase
        end
    end

    // Digit selection and decode for the upcoming cycle. The outputs are
    // registered from the next state so they are aligned with the state
    // register rather than trailing it by a cycle.
    always_comb begin
        w_digit = r_snap[3:0];
        case (w_idxNext)
            2'd0: w_digit = r_snap[3:0];
            2'd1: w_digit = r_snap[7:4];
            2'd2: w_digit = r_snap[11:8];
            2'd3: w_digit = r_snap[15:12];
            default: w_digit = r_snap[3:0];
        endcase

        w_segRaw = 7'h40;
        case (w_digit)
            4'd0: w_segRaw = 7'h3F;
            4'd1: w_segRaw = 7'h06;
            4'd2: w_segRaw = 7'h5B;
            4'd3: w_segRaw = 7'h4F;
            4'd4: w_segRaw = 7'h66;
            4'd5: w_segRaw = 7'h6D;
            4'd6: w_segRaw = 7'h7D;
            4'd7: w_segRaw = 7'h07;
            4'd8: w_segRaw = 7'h7F;
            4'd9: w_segRaw = 7'h6F;
            default: w_segRaw = 7'h40;
        endcase

        w_anOneHot = 4'b0001 << w_idxNext;

        w_anNext  = AN_OFF;
        w_segNext = SEG_OFF;
        if (w_stateNext == ST_SHOW) begin
            w_anNext = (COMMON_ANODE != 0) ? ~w_anOneHot : w_anOneHot;
            // A blanked digit keeps its enable so the scan timing is the same.
            if (!w_lzBlank[w_idxNext]) begin
                w_segNext = (COMMON_ANODE != 0) ? ~w_segRaw : w_segRaw;
            end
        end
    end

    // State, snapshot and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= ST_BLANK;
            r_idx       <= 2'd0;
            r_cnt       <= '0;
            r_snap      <= 16'h0000;
            r_started   <= 1'b0;
            r_an        <= AN_OFF;
            r_seg       <= SEG_OFF;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_idx       <= w_idxNext;
            r_cnt       <= w_cntNext;
            r_started   <= 1'b1;
            r_an        <= w_anNext;
            r_seg       <= w_segNext;
            r_frameDone <= w_snapTake;
            if (w_snapTake) begin
                r_snap <= {thousands, hundreds, tens, ones};
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_display
//
// Drives two copies of bcd_scan_display (leading-zero blanking on and off)
// from the same inputs. Each frame's expected an/seg/frame_done sequence is
// pushed to a queue when the digits for that frame are settled and popped
// one entry per clock as the display scans.
// ---------------------------------------------------------------------------
module tb_bcd_scan_display;

    localparam int DIV       = 4;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * (DIV + BLANK_CYC);

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] segLz;
        logic [6:0] segNoLz;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ones, tens, hundreds, thousands;
    logic [6:0] segLz, segNoLz;
    logic [3:0] anLz, anNoLz;
    logic       fdLz, fdNoLz;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    bcd_scan_display #(
        .DIV(DIV), .BLANK_CYC(BLANK_CYC), .COMMON_ANODE(1), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .seg(segLz), .an(anLz), .frame_done(fdLz)
    );

    bcd_scan_display #(
        .DIV(DIV), .BLANK_CYC(BLANK_CYC), .COMMON_ANODE(1), .BLANK_LZ(0)
    ) dutNoLz (
        .clk(clk), .rst_n(rst_n),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .seg(segNoLz), .an(anNoLz), .frame_done(fdNoLz)
    );

    // Active-low segment pattern for one digit, from the decode table.
    function automatic logic [6:0] segOf(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'h3F;
            4'd1: p = 7'h06;
            4'd2: p = 7'h5B;
            4'd3: p = 7'h4F;
            4'd4: p = 7'h66;
            4'd5: p = 7'h6D;
            4'd6: p = 7'h7D;
            4'd7: p = 7'h07;
            4'd8: p = 7'h7F;
            4'd9: p = 7'h6F;
            default: p = 7'h40;
        endcase
        return ~p;
    endfunction

    // Inputs packed as {thousands, hundreds, tens, ones}.
    task automatic applyStimulus(input logic [15:0] v);
        thousands = v[15:12];
        hundreds  = v[11:8];
        tens      = v[7:4];
        ones      = v[3:0];
    endtask

    // Queue one full frame of expected outputs for snapshot v.
    task automatic pushFrame(input logic [15:0] v);
        logic [3:0] d[4];
        logic [3:0] blank;
        logic [3:0] oneHot;
        exp_t       e;
        d[0] = v[3:0];
        d[1] = v[7:4];
        d[2] = v[11:8];
        d[3] = v[15:12];
        blank[0] = 1'b0;
        blank[1] = (d[3] == 4'd0) && (d[2] == 4'd0) && (d[1] == 4'd0);
        blank[2] = (d[3] == 4'd0) && (d[2] == 4'd0);
        blank[3] = (d[3] == 4'd0);
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < BLANK_CYC; c++) begin
                e.an      = 4'hF;
                e.segLz   = 7'h7F;
                e.segNoLz = 7'h7F;
                e.fd      = (i == 0) && (c == 0);
                expQ.push_back(e);
            end
            oneHot = 4'b0001 << i;
            for (int c = 0; c < DIV; c++) begin
                e.an      = ~oneHot;
                e.segLz   = blank[i] ? 7'h7F : segOf(d[i]);
                e.segNoLz = segOf(d[i]);
                e.fd      = 1'b0;
                expQ.push_back(e);
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [6:0] observed,
                              input logic [6:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input exp_t e, input string where);
        checkValue({where, " an"},         {3'b000, anLz},   {3'b000, e.an});
        checkValue({where, " anNoLz"},     {3'b000, anNoLz}, {3'b000, e.an});
        checkValue({where, " seg"},        segLz,            e.segLz);
        checkValue({where, " segNoLz"},    segNoLz,          e.segNoLz);
        checkValue({where, " frame_done"}, {6'd0, fdLz},     {6'd0, e.fd});
        checkValue({where, " fdNoLz"},     {6'd0, fdNoLz},   {6'd0, e.fd});
    endtask

    task automatic checkDark(input string where);
        exp_t e;
        e.an      = 4'hF;
        e.segLz   = 7'h7F;
        e.segNoLz = 7'h7F;
        e.fd      = 1'b0;
        checkOutput(e, where);
    endtask

    // Compare n consecutive cycles against the queue, optionally changing
    // the inputs right after cycle changeAt. Ends one cycle after the last.
    task automatic consume(input int n, input int changeAt,
                           input logic [15:0] newVals, input string where);
        for (int c = 0; c < n; c++) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s queue: observed=empty expected=entry", where);
            end else begin
                checkOutput(expQ.pop_front(), $sformatf("%s c%0d", where, c));
            end
            if (c == changeAt) applyStimulus(newVals);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(16'h4321);
        repeat (3) begin
            @(negedge clk);
            checkDark("reset");
        end

        rst_n = 1'b0;
        pushFrame(16'h4321);
        @(negedge clk);
        // Change ones during SHOW of idx 2: current frame must keep the old value.
        consume(FRAME, 15, 16'h4329, "f1234");

        pushFrame(16'h4329);
        consume(FRAME, 3, 16'h0007, "fOnes9");

        pushFrame(16'h0007);
        consume(FRAME, 10, 16'h0500, "fLz7");

        pushFrame(16'h0500);
        consume(FRAME, 20, 16'hC000, "fHund5");

        pushFrame(16'hC000);
        consume(FRAME, 1, 16'h0865, "fDash");

        // Reset during SHOW of idx 1.
        pushFrame(16'h0865);
        consume(10, -1, 16'h0865, "fPreReset");
        rst_n = 1'b1;
        expQ.delete();
        @(negedge clk);
        checkDark("midReset");

        applyStimulus(16'h0000);
        rst_n = 1'b0;
        pushFrame(16'h0000);
        @(negedge clk);
        consume(FRAME, -1, 16'h0000, "fAfterReset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
